// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes one instruction, drives the register-file
// read ports, resolves operands with write-back bypass, and hands a packet to EX.
module id_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid_i,
    output logic               inst_ready_o,
    input  logic [XLEN-1:0]    inst_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic               re1_o,
    output logic [RADDR_W-1:0] raddr1_o,
    input  logic [XLEN-1:0]    rdata1_i,
    output logic               re2_o,
    output logic [RADDR_W-1:0] raddr2_o,
    input  logic [XLEN-1:0]    rdata2_i,
    input  logic               wb_we_i,
    input  logic [RADDR_W-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]    wb_wdata_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [3:0]         ex_class_o,
    output logic [2:0]         ex_funct3_o,
    output logic               ex_f7b5_o,
    output logic [XLEN-1:0]    ex_reg1_o,
    output logic [XLEN-1:0]    ex_reg2_o,
    output logic [XLEN-1:0]    ex_imm_o,
    output logic [RADDR_W-1:0] ex_wd_o,
    output logic               ex_wreg_o
);

    typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

    localparam logic [3:0] C_ILLEGAL = 4'd0;
    localparam logic [3:0] C_OP_IMM  = 4'd1;
    localparam logic [3:0] C_OP      = 4'd2;
    localparam logic [3:0] C_LUI     = 4'd3;
    localparam logic [3:0] C_AUIPC   = 4'd4;
    localparam logic [3:0] C_JAL     = 4'd5;
    localparam logic [3:0] C_JALR    = 4'd6;
    localparam logic [3:0] C_BRANCH  = 4'd7;
    localparam logic [3:0] C_LOAD    = 4'd8;
    localparam logic [3:0] C_STORE   = 4'd9;

    state_t state, state_next;

    logic [XLEN-1:0]    inst_p0, pc_p0;
    logic               byp1_hit_p0, byp2_hit_p0;
    logic [XLEN-1:0]    byp1_data_p0, byp2_data_p0;
    logic               accept;
    logic [3:0]         cls_in, cls_p0;
    logic [RADDR_W-1:0] rs1_p0, rs2_p0;
    logic               use1_p0, use2_p0;
    logic               wb_hit1, wb_hit2;
    logic [XLEN-1:0]    op1, op2;

    function automatic logic [3:0] decode_class(input logic [XLEN-1:0] ins);
        case (ins[6:0])
            7'h13:   decode_class = C_OP_IMM;
            7'h33:   decode_class = C_OP;
            7'h37:   decode_class = C_LUI;
            7'h17:   decode_class = C_AUIPC;
            7'h6F:   decode_class = C_JAL;
            7'h67:   decode_class = C_JALR;
            7'h63:   decode_class = C_BRANCH;
            7'h03:   decode_class = C_LOAD;
            7'h23:   decode_class = C_STORE;
            default: decode_class = C_ILLEGAL;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [3:0] cls);
        uses_rs1 = (cls == C_OP_IMM) || (cls == C_OP) || (cls == C_JALR) ||
                   (cls == C_BRANCH) || (cls == C_LOAD) || (cls == C_STORE);
    endfunction

    function automatic logic uses_rs2(input logic [3:0] cls);
        uses_rs2 = (cls == C_OP) || (cls == C_BRANCH) || (cls == C_STORE);
    endfunction

    function automatic logic writes_rd(input logic [3:0] cls);
        writes_rd = (cls == C_OP_IMM) || (cls == C_OP) || (cls == C_LUI) ||
                    (cls == C_AUIPC) || (cls == C_JAL) || (cls == C_JALR) ||
                    (cls == C_LOAD);
    endfunction

    function automatic logic [XLEN-1:0] decode_imm(input logic [XLEN-1:0] ins,
                                                   input logic [3:0] cls);
        case (cls)
            C_OP_IMM, C_JALR, C_LOAD:
                decode_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            C_STORE:
                decode_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            C_BRANCH:
                decode_imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25],
                              ins[11:8], 1'b0};
            C_LUI, C_AUIPC:
                decode_imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
            C_JAL:
                decode_imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20],
                              ins[30:21], 1'b0};
            default:
                decode_imm = '0;
        endcase
    endfunction

    // Operand priority: unused/x0, same-cycle write, accept-cycle write, register file.
    function automatic logic [XLEN-1:0] resolve(input logic used,
                                                input logic [RADDR_W-1:0] rs,
                                                input logic wb_hit,
                                                input logic [XLEN-1:0] wb_data,
                                                input logic byp_hit,
                                                input logic [XLEN-1:0] byp_data,
                                                input logic [XLEN-1:0] rdata);
        if (!used || rs == '0)
            resolve = '0;
        else if (wb_hit)
            resolve = wb_data;
        else if (byp_hit)
            resolve = byp_data;
        else
            resolve = rdata;
    endfunction

    assign inst_ready_o = !rst && ((state == IDLE) || ((state == OUT) && ex_ready_i));
    assign accept       = inst_valid_i && inst_ready_o;

    assign cls_in   = decode_class(inst_i);
    assign raddr1_o = inst_i[19:15];
    assign raddr2_o = inst_i[24:20];
    // x0 is never read: its operand is forced to zero anyway.
    assign re1_o    = accept && uses_rs1(cls_in) && (inst_i[19:15] != '0);
    assign re2_o    = accept && uses_rs2(cls_in) && (inst_i[24:20] != '0);

    assign cls_p0  = decode_class(inst_p0);
    assign rs1_p0  = inst_p0[19:15];
    assign rs2_p0  = inst_p0[24:20];
    assign use1_p0 = uses_rs1(cls_p0);
    assign use2_p0 = uses_rs2(cls_p0);
    assign wb_hit1 = wb_we_i && (wb_waddr_i == rs1_p0) && (rs1_p0 != '0) && use1_p0;
    assign wb_hit2 = wb_we_i && (wb_waddr_i == rs2_p0) && (rs2_p0 != '0) && use2_p0;
    assign op1 = resolve(use1_p0, rs1_p0, wb_hit1, wb_wdata_i, byp1_hit_p0, byp1_data_p0, rdata1_i);
    assign op2 = resolve(use2_p0, rs2_p0, wb_hit2, wb_wdata_i, byp2_hit_p0, byp2_data_p0, rdata2_i);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = OUT;
            OUT:     if (ex_ready_i) state_next = accept ? READ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // p0: instruction latched at accept; p1: decode packet presented to EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_p0      <= '0;
            pc_p0        <= '0;
            byp1_hit_p0  <= 1'b0;
            byp2_hit_p0  <= 1'b0;
            byp1_data_p0 <= '0;
            byp2_data_p0 <= '0;
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_class_o   <= '0;
            ex_funct3_o  <= '0;
            ex_f7b5_o    <= 1'b0;
            ex_reg1_o    <= '0;
            ex_reg2_o    <= '0;
            ex_imm_o     <= '0;
            ex_wd_o      <= '0;
            ex_wreg_o    <= 1'b0;
        end else begin
            if (accept) begin
                inst_p0      <= inst_i;
                pc_p0        <= pc_i;
                byp1_hit_p0  <= wb_we_i && (wb_waddr_i == inst_i[19:15]);
                byp2_hit_p0  <= wb_we_i && (wb_waddr_i == inst_i[24:20]);
                byp1_data_p0 <= wb_wdata_i;
                byp2_data_p0 <= wb_wdata_i;
            end
            case (state)
                READ: begin
                    ex_valid_o  <= 1'b1;
                    ex_pc_o     <= pc_p0;
                    ex_class_o  <= cls_p0;
                    ex_funct3_o <= inst_p0[14:12];
                    ex_f7b5_o   <= inst_p0[30];
                    ex_reg1_o   <= op1;
                    ex_reg2_o   <= op2;
                    ex_imm_o    <= decode_imm(inst_p0, cls_p0);
                    ex_wd_o     <= inst_p0[11:7];
                    ex_wreg_o   <= writes_rd(cls_p0) && (inst_p0[11:7] != '0);
                end
                OUT: begin
                    if (ex_ready_i) begin
                        ex_valid_o <= 1'b0;
                    end else begin
                        // Held packet keeps tracking write-back so it never goes stale.
                        if (wb_hit1) ex_reg1_o <= wb_wdata_i;
                        if (wb_hit2) ex_reg2_o <= wb_wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table through a scoreboard, plus
// hand-written bypass, stall and reset-in-flight sequences.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst, pc;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc;
    logic [3:0]  ex_class;
    logic [2:0]  ex_funct3;
    logic        ex_f7b5;
    logic [31:0] ex_reg1, ex_reg2, ex_imm;
    logic [4:0]  ex_wd;
    logic        ex_wreg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        re1;
        logic        re2;
        logic [3:0]  cls;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] imm;
        logic [4:0]  wd;
        logic        wreg;
    } vec_t;

    vec_t tbl[11];
    vec_t sb[$];

    id_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
        .inst_i(inst), .pc_i(pc),
        .re1_o(re1), .raddr1_o(raddr1), .rdata1_i(rdata1),
        .re2_o(re2), .raddr2_o(raddr2), .rdata2_i(rdata2),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_pc_o(ex_pc), .ex_class_o(ex_class), .ex_funct3_o(ex_funct3),
        .ex_f7b5_o(ex_f7b5), .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2),
        .ex_imm_o(ex_imm), .ex_wd_o(ex_wd), .ex_wreg_o(ex_wreg)
    );

    always #5 clk = ~clk;

    // Register file: registered read data, read-before-write, x0 never written.
    logic [31:0] rf[32];
    always @(posedge clk) begin
        if (re1) rdata1 <= rf[raddr1];
        if (re2) rdata2 <= rf[raddr2];
        if (wb_we && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_packet_pc", ex_pc, 32'hDEAD_BEEF);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("pkt.pc",     ex_pc,            e.pc);
                chk("pkt.class",  {28'd0, ex_class}, {28'd0, e.cls});
                chk("pkt.funct3", {29'd0, ex_funct3}, {29'd0, e.inst[14:12]});
                chk("pkt.f7b5",   {31'd0, ex_f7b5}, {31'd0, e.inst[30]});
                chk("pkt.reg1",   ex_reg1,          e.reg1);
                chk("pkt.reg2",   ex_reg2,          e.reg2);
                chk("pkt.imm",    ex_imm,           e.imm);
                chk("pkt.wd",     {27'd0, ex_wd},   {27'd0, e.wd});
                chk("pkt.wreg",   {31'd0, ex_wreg}, {31'd0, e.wreg});
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_ready && n < 50);
        if (!inst_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input vec_t v);
        @(posedge clk); #1;
        inst_valid = 1'b1;
        inst       = v.inst;
        pc         = v.pc;
        wait_ready("send");
        chk("acc.re1",    {31'd0, re1}, {31'd0, v.re1});
        chk("acc.re2",    {31'd0, re2}, {31'd0, v.re2});
        chk("acc.raddr1", {27'd0, raddr1}, {27'd0, v.inst[19:15]});
        chk("acc.raddr2", {27'd0, raddr2}, {27'd0, v.inst[24:20]});
        sb.push_back(v);
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ex_valid && n < 20);
        chk("valid_seen", {31'd0, ex_valid}, 32'd1);
    endtask

    initial begin
        // inst, pc, re1, re2, class, reg1, reg2, imm, wd, wreg   (x1=0x11, x2=7, x3=9)
        tbl[0]  = '{32'h00500093, 32'h100, 1'b0, 1'b0, 4'd1, 32'h0,  32'h0, 32'h5,        5'd1,  1'b1};
        tbl[1]  = '{32'h00310233, 32'h104, 1'b1, 1'b1, 4'd2, 32'h7,  32'h9, 32'h0,        5'd4,  1'b1};
        tbl[2]  = '{32'hFE208EE3, 32'h108, 1'b1, 1'b1, 4'd7, 32'h11, 32'h7, 32'hFFFFFFFC, 5'd29, 1'b0};
        tbl[3]  = '{32'h00000000, 32'h10C, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0, 32'h0,        5'd0,  1'b0};
        tbl[4]  = '{32'h123452B7, 32'h110, 1'b0, 1'b0, 4'd3, 32'h0,  32'h0, 32'h12345000, 5'd5,  1'b1};
        tbl[5]  = '{32'h00312423, 32'h114, 1'b1, 1'b1, 4'd9, 32'h7,  32'h9, 32'h8,        5'd8,  1'b0};
        tbl[6]  = '{32'h010000EF, 32'h118, 1'b0, 1'b0, 4'd5, 32'h0,  32'h0, 32'h10,       5'd1,  1'b1};
        tbl[7]  = '{32'h0040A003, 32'h11C, 1'b1, 1'b0, 4'd8, 32'h11, 32'h0, 32'h4,        5'd0,  1'b0};
        tbl[8]  = '{32'hFFF18167, 32'h120, 1'b1, 1'b0, 4'd6, 32'h9,  32'h0, 32'hFFFFFFFF, 5'd2,  1'b1};
        tbl[9]  = '{32'h80000397, 32'h124, 1'b0, 1'b0, 4'd4, 32'h0,  32'h0, 32'h80000000, 5'd7,  1'b1};
        tbl[10] = '{32'h00500091, 32'h128, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0, 32'h0,        5'd1,  1'b0};

        rst = 1'b1; inst_valid = 1'b0; inst = '0; pc = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; ex_ready = 1'b1;

        // Preload the register file through the snoop port while held in reset.
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            wb_we = 1'b1; wb_waddr = 5'(i);
            wb_wdata = (i == 1) ? 32'h11 : (i == 2) ? 32'h7 : 32'h9;
        end
        @(posedge clk); #1;
        wb_we = 1'b0;
        @(negedge clk);
        chk("rst.inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst.ex_valid",   {31'd0, ex_valid},   32'd0);
        chk("rst.ex_pc",      ex_pc,               32'd0);
        chk("rst.ex_reg1",    ex_reg1,             32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.inst_ready", {31'd0, inst_ready}, 32'd1);

        for (int i = 0; i < 11; i++) send(tbl[i]);
        drain();

        // Bypass: x2 written in the accept cycle, x3 in the READ cycle.
        begin
            vec_t v;
            v = '{32'h00310233, 32'h200, 1'b1, 1'b1, 4'd2, 32'h55, 32'h66, 32'h0, 5'd4, 1'b1};
            @(posedge clk); #1;
            inst_valid = 1'b1; inst = v.inst; pc = v.pc;
            wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h55;
            wait_ready("byp");
            sb.push_back(v);
            @(posedge clk); #1;
            inst_valid = 1'b0; wb_waddr = 5'd3; wb_wdata = 32'h66;
            @(negedge clk);
            chk("byp.valid_at_read", {31'd0, ex_valid}, 32'd0);
            @(posedge clk); #1;
            wb_we = 1'b0;
            @(negedge clk);
            chk("byp.valid_latency", {31'd0, ex_valid}, 32'd1);
            drain();
        end

        // Stall: packet held 3 cycles, write to x3 overwrites held operand.
        begin
            vec_t v, n2;
            v  = '{32'h00310233, 32'h300, 1'b1, 1'b1, 4'd2, 32'h55, 32'h77, 32'h0, 5'd4, 1'b1};
            n2 = '{32'h00118313, 32'h304, 1'b1, 1'b0, 4'd1, 32'h77, 32'h0,  32'h1, 5'd6, 1'b1};
            @(posedge clk); #1;
            ex_ready = 1'b0;
            send(v);
            wait_valid();
            chk("stall.reg2_before", ex_reg2, 32'h66);
            chk("stall.ready0",      {31'd0, inst_ready}, 32'd0);
            @(posedge clk); #1;
            wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h77;
            inst_valid = 1'b1; inst = n2.inst; pc = n2.pc;
            @(negedge clk);
            chk("stall.ready1", {31'd0, inst_ready}, 32'd0);
            chk("stall.valid1", {31'd0, ex_valid},   32'd1);
            @(posedge clk); #1;
            wb_we = 1'b0;
            @(negedge clk);
            chk("stall.reg2_after", ex_reg2, 32'h77);
            chk("stall.pc_held",    ex_pc,   32'h300);
            @(posedge clk); #1;
            ex_ready = 1'b1;
            @(negedge clk);
            chk("stall.accept_same_cycle", {31'd0, inst_ready}, 32'd1);
            chk("stall.re1",               {31'd0, re1},        32'd1);
            sb.push_back(n2);
            @(posedge clk); #1;
            inst_valid = 1'b0;
            drain();
        end

        // Reset while the instruction sits in READ: nothing must come out.
        @(posedge clk); #1;
        inst_valid = 1'b1; inst = 32'h00500093; pc = 32'h400;
        wait_ready("rst_read");
        @(posedge clk); #1;
        inst_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_read.ready_in_rst", {31'd0, inst_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_read.valid",  {31'd0, ex_valid},   32'd0);
        chk("rst_read.ready",  {31'd0, inst_ready}, 32'd1);
        chk("rst_read.ex_pc",  ex_pc,               32'd0);
        @(negedge clk);
        chk("rst_read.valid2", {31'd0, ex_valid},   32'd0);
        repeat (3) @(negedge clk);
        chk("rst_read.no_stale", {31'd0, ex_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d want 0", 1);
        $fatal(1, "timeout");
    end

endmodule
